// File: rtl/gol_pkg.sv
// Shared types and constants for the GOL row-scan display driver.
// The BLANK state exists only when GOL_ROW_BLANK_EN is defined.
package gol_pkg;

  typedef logic [63:0] grid_t;
  typedef logic [7:0]  row_t;

`ifdef GOL_ROW_BLANK_EN
  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StBlank
  } scan_state_t;
`else
  typedef enum logic [1:0] {
    StIdle,
    StShow
  } scan_state_t;
`endif

  localparam int unsigned DWELL_DEFAULT = 1000;

  function automatic row_t row_onehot(input logic [2:0] idx);
    return row_t'(8'd1 << idx);
  endfunction

endpackage

// File: rtl/gol_row_timer.sv
// Loadable down-counter; expire_o is high on the terminal (zero) cycle.
module gol_row_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/gol_row_scan.sv
// Row-multiplexed 8x8 display scanner with a one-deep pending generation buffer.
// Define GOL_ROW_BLANK_EN to insert BLANK cycles of dark time after every row.
module gol_row_scan
  import gol_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT,
  parameter int unsigned BLANK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  output logic        grid_ready,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic        busy
);

  if (DWELL < 2 || DWELL > 65535 || BLANK < 1 || BLANK > 255) begin : g_param_check
    $error("gol_row_scan: DWELL or BLANK out of range");
  end

  localparam logic [15:0] DwellLoad = 16'(DWELL - 1);

  scan_state_t state_q;
  logic [2:0]  row_q;
  grid_t       pending_q, display_q;
  logic        pending_full_q, pending_full_d;
  logic        wrap_q;

  logic accept, start, row_end, step, wrap, transfer;
  logic dwell_load, dwell_expire;

`ifdef GOL_ROW_BLANK_EN
  localparam logic [7:0] BlankLoad = 8'(BLANK - 1);
  logic blank_load, blank_expire;
`endif

  always_comb begin
    accept  = grid_valid && grid_ready;
    start   = (state_q == StIdle) && pending_full_q;
    row_end = (state_q == StShow) && dwell_expire;
`ifdef GOL_ROW_BLANK_EN
    blank_load = row_end;
    step       = (state_q == StBlank) && blank_expire;
`else
    step       = row_end;
`endif
    wrap       = step && (row_q == 3'd7);
    dwell_load = start || step;
    // Display only reloads at frame boundaries, so a frame never tears.
    transfer   = start || (wrap && pending_full_q);
    pending_full_d = pending_full_q;
    if (transfer) begin
      pending_full_d = 1'b0;
    end else if (accept) begin
      pending_full_d = 1'b1;
    end
  end

  gol_row_timer #(
    .Width (16)
  ) u_dwell_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (dwell_load),
    .load_val_i (DwellLoad),
    .expire_o   (dwell_expire)
  );

`ifdef GOL_ROW_BLANK_EN
  gol_row_timer #(
    .Width (8)
  ) u_blank_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (blank_load),
    .load_val_i (BlankLoad),
    .expire_o   (blank_expire)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      row_q          <= '0;
      pending_q      <= '0;
      display_q      <= '0;
      pending_full_q <= 1'b0;
      wrap_q         <= 1'b0;
      grid_ready     <= 1'b1;
      row_sel        <= '0;
      col_data       <= '0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      pending_full_q <= pending_full_d;
      grid_ready     <= !pending_full_d;
      if (accept) begin
        pending_q <= grid_in;
      end
      if (transfer) begin
        display_q <= pending_q;
      end

      if (start) begin
        state_q <= StShow;
        row_q   <= '0;
`ifdef GOL_ROW_BLANK_EN
      end else if (row_end) begin
        state_q <= StBlank;
      end else if (step) begin
        state_q <= StShow;
        row_q   <= row_q + 3'd1;
`else
      end else if (step) begin
        row_q   <= row_q + 3'd1;
`endif
      end

      // Output stage lags the FSM by one edge; frame_done lines up with row 0.
      wrap_q     <= wrap;
      frame_done <= wrap_q;
      busy       <= (state_q != StIdle) || start;
      row_sel    <= (state_q == StShow) ? row_onehot(row_q) : '0;
      col_data   <= (state_q == StShow) ? display_q[{row_q, 3'b000} +: 8] : '0;
    end
  end

endmodule

// File: tb/tb_gol_row_scan.sv
// Scoreboard bench for gol_row_scan; expectations adapt to GOL_ROW_BLANK_EN.
module tb_gol_row_scan;
  import gol_pkg::*;

  localparam int unsigned DW = 4;
  localparam int unsigned BL = 2;
`ifdef GOL_ROW_BLANK_EN
  localparam int unsigned GAP = BL;
`else
  localparam int unsigned GAP = 0;
`endif
  localparam int unsigned PERIOD = 8 * (DW + GAP);

  localparam grid_t G_FF   = 64'h0000_0000_0000_00FF;
  localparam grid_t G_DIAG = 64'h8040_2010_0804_0201;
  localparam grid_t G_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam grid_t G_IGN  = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam grid_t G_SEQ  = 64'h0F0E_0D0C_0B0A_0908;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] grid_in;
  logic        grid_valid;
  logic        grid_ready;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;
  logic        busy;

  always #5 clk = ~clk;

  gol_row_scan #(
    .DWELL (DW),
    .BLANK (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .grid_in    (grid_in),
    .grid_valid (grid_valid),
    .grid_ready (grid_ready),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  typedef struct packed {
    row_t sel;
    row_t dat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input grid_t g);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < int'(DW); k++) begin
        sb_q.push_back({row_t'(8'd1 << r), g[8*r +: 8]});
      end
    end
  endtask

  // Called at posedge+1; acceptance happens on the next edge.
  task automatic handshake(input grid_t g);
    grid_in    = g;
    grid_valid = 1'b1;
    step();
    grid_valid = 1'b0;
  endtask

  task automatic wait_row(input row_t v);
    int b = 0;
    while (row_sel !== v && b < 500) begin
      step();
      b++;
    end
    check("wait_row", row_sel, v);
  endtask

  // Reset right after the last expected output so nothing unscheduled is shown.
  task automatic drain_then_reset();
    int b = 0;
    while (sb_q.size() != 0 && b < 2000) begin
      @(negedge clk);
      #1;
      b++;
    end
    check("drain", sb_q.size(), 0);
    sb_q.delete();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Monitor: pops an expectation for every lit row cycle; checks gaps and frame period.
  initial begin
    exp_t e;
    logic lit_seen = 1'b0;
    logic fd_seen  = 1'b0;
    row_t prev_sel = '0;
    int   gap      = 0;
    int   last_fd  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        lit_seen = 1'b0;
        fd_seen  = 1'b0;
        gap      = 0;
      end else begin
        if (row_sel != 8'h00) begin
          if (lit_seen && row_sel != prev_sel) check("row_gap", gap, GAP);
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_row: got row_sel %0h col_data %0h, expected no output",
                     row_sel, col_data);
          end else begin
            e = sb_q.pop_front();
            check("row_sel", row_sel, e.sel);
            check("col_data", col_data, e.dat);
          end
          lit_seen = 1'b1;
          prev_sel = row_sel;
          gap      = 0;
        end else if (busy) begin
          check("dark_col_data", col_data, 0);
          if (lit_seen) gap++;
        end
        if (frame_done) begin
          if (fd_seen) check("frame_period", cyc - last_fd, PERIOD);
          fd_seen = 1'b1;
          last_fd = cyc;
          fd_cnt++;
        end
      end
    end
  end

  initial begin
    int fd0;
    reset      = 1'b1;
    grid_valid = 1'b0;
    grid_in    = '0;
    repeat (3) step();
    check("rst_row_sel", row_sel, 0);
    check("rst_col_data", col_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_grid_ready", grid_ready, 1);
    reset = 1'b0;
    step();

    // Single accept: ready drops one cycle, row 0 shows two edges later.
    push_frame(G_FF);
    handshake(G_FF);
    check("ready_low_after_accept", grid_ready, 0);
    check("row_sel_n1", row_sel, 8'h00);
    step();
    check("ready_back_high", grid_ready, 1);
    check("busy_n1", busy, 1);
    check("row_sel_n1_dark", row_sel, 8'h00);
    step();
    check("row_sel_n2", row_sel, 8'h01);
    check("col_data_n2", col_data, 8'hFF);
    drain_then_reset();

    // Diagonal over three frames: row timing and frame_done cadence.
    fd0 = fd_cnt;
    push_frame(G_DIAG);
    push_frame(G_DIAG);
    push_frame(G_DIAG);
    handshake(G_DIAG);
    drain_then_reset();
    check("frame_done_count", fd_cnt - fd0, 2);

    // Mid-frame update shows next frame; a second valid while full is ignored.
    push_frame(G_DIAG);
    push_frame(G_ONES);
    push_frame(G_ONES);
    handshake(G_DIAG);
    wait_row(8'h08);
    handshake(G_ONES);
    check("ready_pending_full", grid_ready, 0);
    grid_in    = G_IGN;
    grid_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ready_held_low", grid_ready, 0);
    end
    grid_valid = 1'b0;
    drain_then_reset();

    // Reset at row 3 discards the frame; FSM idles until a new handshake.
    push_frame(G_DIAG);
    handshake(G_DIAG);
    wait_row(8'h08);
    reset = 1'b1;
    step();
    sb_q.delete();
    check("midrst_row_sel", row_sel, 0);
    check("midrst_col_data", col_data, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_grid_ready", grid_ready, 1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_busy", busy, 0);
      check("idle_row_sel", row_sel, 0);
    end
    push_frame(G_SEQ);
    handshake(G_SEQ);
    step();
    step();
    check("restart_row_sel", row_sel, 8'h01);
    check("restart_col_data", col_data, 8'h08);
    drain_then_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
